aes_round_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 40 ++++
 rtl/SubBytes.sv | 15 +
 rtl/aes_key_step.sv | 28 ++
 rtl/aes_round_ctrl.sv | 83 ++++++++
 tb/tb_aes_round_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM states, S-box and rcon helpers
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  // Forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/SubBytes.sv
// rtl/SubBytes.sv - byte-wise S-box substitution over NB bytes
module SubBytes
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [8*NB-1:0] din,
  output logic [8*NB-1:0] dout
);

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one AES-128 key-schedule step, combinational
module aes_key_step (
  input  logic [127:0] rk_in,
  input  logic [7:0]   rc,
  output logic [127:0] rk_out
);

  logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

  assign w0  = rk_in[127:96];
  assign w1  = rk_in[95:64];
  assign w2  = rk_in[63:32];
  assign w3  = rk_in[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  SubBytes #(.NB(4)) u_sub (
    .din  (rot),
    .dout (sub)
  );

  assign t  = sub ^ {rc, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 controller driving an external round core
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ptext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ctext,
  output logic [127:0] core_din,
  output logic [127:0] core_kin,
  output logic         core_sel,
  input  logic [127:0] core_dout
);

  import aes_pkg::*;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q, rk_q, step_key;
  logic [3:0]   rnd_q;
  logic [7:0]   rc_cur;
  logic         accept, last_rnd;

  assign rc_cur   = rcon(rnd_q);
  assign accept   = in_valid && (fsm_q == IDLE);
  assign last_rnd = (rnd_q == 4'(NR));

  aes_key_step u_key_step (
    .rk_in  (rk_q),
    .rc     (rc_cur),
    .rk_out (step_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = RUN;
      RUN:     if (last_rnd) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Core output arrives inverted; undo it on capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= '0;
      rk_q  <= '0;
      rnd_q <= '0;
    end else if (fsm_q == IDLE && accept) begin
      st_q  <= ptext ^ key;
      rk_q  <= key;
      rnd_q <= 4'd1;
    end else if (fsm_q == RUN) begin
      st_q  <= ~core_dout;
      rk_q  <= step_key;
      rnd_q <= rnd_q + 4'd1;
    end
  end

  always_comb begin
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    ctext     = st_q;
    core_din  = st_q;
    core_kin  = '0;
    core_sel  = 1'b0;
    if (fsm_q == RUN) begin
      core_kin = step_key;
      core_sel = last_rnd;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl with a behavioural round core
module tb_aes_round_ctrl;

  logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, core_sel;
  logic [127:0] ptext = '0, key = '0;
  logic [127:0] ctext, core_din, core_kin, core_dout;

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int checks = 0, passes = 0, cyc = 0;
  int m_phase = 0, acc_cnt = 0;
  int acc_cyc [16];
  logic m_fresh = 1'b1, chk_en = 1'b0;
  logic [127:0] m_ct = '0, m_key = '0;

  aes_round_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ptext     (ptext),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctext     (ctext),
    .core_din  (core_din),
    .core_kin  (core_kin),
    .core_sel  (core_sel),
    .core_dout (core_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] w, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h0};
    n0 = w[127:96] ^ t;
    n1 = w[95:64] ^ n0;
    n2 = w[63:32] ^ n1;
    n3 = w[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [127:0] w = k;
    logic [7:0] rc = 8'h01;
    for (int i = 1; i <= r; i++) begin
      w  = key_next(w, rc);
      rc = gmul(rc, 8'h02);
    end
    return w;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s = p ^ k;
    for (int r = 1; r <= 10; r++) s = aes_round(s, round_key(k, r), r == 10);
    return s;
  endfunction

  // Behavioural round core with inverted output
  assign core_dout = ~aes_round(core_din, core_kin, core_sel);

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Block-level model: phase 0 idle, 1..10 round r, 11 result held
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_fresh <= 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase <= 1;
          m_key   <= key;
          m_ct    <= aes_encrypt(ptext, key);
          m_fresh <= 1'b0;
          acc_cyc[acc_cnt & 15] <= cyc;
          acc_cnt <= acc_cnt + 1;
        end
        11: if (out_ready) m_phase <= 0;
        default: m_phase <= m_phase + 1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {127'b0, in_ready}, {127'b0, m_phase == 0});
      chk("out_valid", {127'b0, out_valid}, {127'b0, m_phase == 11});
      chk("core_sel", {127'b0, core_sel}, {127'b0, m_phase == 10});
      chk("core_kin", core_kin,
          (m_phase >= 1 && m_phase <= 10) ? round_key(m_key, m_phase) : 128'h0);
      if (m_phase == 11) chk("ctext_done", ctext, m_ct);
      if (m_phase == 0 && m_fresh) chk("ctext_after_reset", ctext, 128'h0);
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      $display("FAIL %s: out_valid not seen within 40 cycles", name);
    end
  endtask

  task automatic wait_acc(input string name, input int target);
    int n = 0;
    while (acc_cnt < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt < target) begin
      checks++;
      $display("FAIL %s: accept not seen within 40 cycles", name);
    end
  endtask

  initial begin
    int base;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", {127'b0, in_ready}, 128'h1);
    chk("reset_out_valid", {127'b0, out_valid}, 128'h0);
    chk("reset_ctext", ctext, 128'h0);
    chk("reset_core_kin", core_kin, 128'h0);
    chk("reset_core_sel", {127'b0, core_sel}, 128'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // FIPS-197 App. B with fixed latency
    ptext = B_PT; key = B_KEY; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b_kin_r1", core_kin, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("b_sel_r1", {127'b0, core_sel}, 128'h0);
    repeat (9) @(negedge clk);
    chk("b_kin_r10", core_kin, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("b_sel_r10", {127'b0, core_sel}, 128'h1);
    @(negedge clk);
    chk("b_valid_latency", {127'b0, out_valid}, 128'h1);
    chk("b_ctext", ctext, B_CT);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b_back_idle", {127'b0, in_ready}, 128'h1);

    // App. C.1 under 20 cycles of back-pressure with a stray in_valid pulse
    ptext = C_PT; key = C_KEY; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("c1");
    chk("c1_ctext", ctext, C_CT);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 5);
      if (i == 5) ptext = B_PT;
      @(negedge clk);
      chk("bp_ctext", ctext, C_CT);
      chk("bp_in_ready", {127'b0, in_ready}, 128'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_pulse_ignored", {127'b0, in_ready}, 128'h1);

    // Back-to-back with in_valid and out_ready held high
    base = acc_cnt;
    ptext = B_PT; key = B_KEY; in_valid = 1'b1; out_ready = 1'b1;
    wait_acc("b2b_acc0", base + 1);
    ptext = C_PT; key = C_KEY;
    wait_valid("b2b_out0");
    chk("b2b_ctext0", ctext, B_CT);
    wait_acc("b2b_acc1", base + 2);
    in_valid = 1'b0;
    wait_valid("b2b_out1");
    chk("b2b_ctext1", ctext, C_CT);
    chk("b2b_accept_gap", 128'(acc_cyc[(base + 1) & 15] - acc_cyc[base & 15]), 128'd12);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during round 5, then a fresh App. B block
    ptext = B_PT; key = B_KEY; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_in_ready", {127'b0, in_ready}, 128'h1);
    chk("midrun_rst_out_valid", {127'b0, out_valid}, 128'h0);
    chk("midrun_rst_ctext", ctext, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ptext = B_PT; key = B_KEY; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("post_rst");
    chk("post_rst_ctext", ctext, B_CT);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
